// File: rtl/run_ctrl.sv
// run_ctrl: host-facing run sequencer for the core (IDLE -> CLEAR -> RUN -> DONE).
// Define RUN_CTRL_WDOG_EN to compile in the RUN-cycle watchdog that drives timeout.
module run_ctrl #(
    parameter int D          = 32'd12,
    parameter int END_ADDR   = 32'd128,
    parameter int CW         = 32'd16,
    parameter int WDOG_LIMIT = 32'h0000_FFF0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  prog_ctr,
    output logic          core_clr,
    output logic          core_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    localparam logic [1:0]    ST_IDLE  = 2'd0;
    localparam logic [1:0]    ST_CLEAR = 2'd1;
    localparam logic [1:0]    ST_RUN   = 2'd2;
    localparam logic [1:0]    ST_DONE  = 2'd3;
    localparam logic [D-1:0]  END_PC   = D'(END_ADDR);
    localparam logic [CW-1:0] CYC_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CYC_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CYC_MAX  = {CW{1'b1}};

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic [CW-1:0] cycles_r;
    logic [CW-1:0] cycles_nxt_s;
    logic          req_q_r;
    logic          armed_r;
    logic          core_clr_r;
    logic          busy_r;
    logic          done_r;
    logic          start_s;
    logic          at_end_s;
    logic          wdog_hit_s;

    // armed_r blocks a start from a req that was already high when reset released
    assign start_s  = req && !req_q_r && armed_r;
    assign at_end_s = (prog_ctr == END_PC);

`ifdef RUN_CTRL_WDOG_EN
    localparam logic [CW-1:0] WDOG_LIM = CW'(WDOG_LIMIT);

    logic timeout_r;
    logic timeout_nxt_s;

    assign wdog_hit_s = (cycles_r == WDOG_LIM);

    // Timeout flag: cleared when a run starts, set when the watchdog ends a run.
    always_comb begin
        timeout_nxt_s = timeout_r;
        if ((state_r == ST_IDLE) && start_s) begin
            timeout_nxt_s = 1'b0;
        end else if ((state_r == ST_RUN) && !at_end_s && wdog_hit_s) begin
            timeout_nxt_s = 1'b1;
        end else begin
            timeout_nxt_s = timeout_r;
        end
    end

    // Timeout register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= timeout_nxt_s;
        end
    end

    assign timeout = timeout_r;
`else
    assign wdog_hit_s = 1'b0;
    assign timeout    = 1'b0;
`endif

    // Next state and cycle count; END_ADDR match wins over the watchdog.
    always_comb begin
        state_nxt_s  = state_r;
        cycles_nxt_s = cycles_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s  = ST_CLEAR;
                    cycles_nxt_s = CYC_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_nxt_s  = ST_RUN;
                cycles_nxt_s = CYC_ZERO;
            end
            ST_RUN: begin
                if (at_end_s) begin
                    state_nxt_s = ST_DONE;
                end else if (wdog_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                    if (cycles_r != CYC_MAX) begin
                        cycles_nxt_s = cycles_r + CYC_ONE;
                    end else begin
                        cycles_nxt_s = cycles_r;
                    end
                end
            end
            ST_DONE: begin
                if (!req) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                cycles_nxt_s = CYC_ZERO;
            end
        endcase
    end

    // State, counters and Moore outputs registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cycles_r   <= CYC_ZERO;
            req_q_r    <= 1'b0;
            armed_r    <= 1'b0;
            core_clr_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cycles_r   <= cycles_nxt_s;
            req_q_r    <= req;
            armed_r    <= armed_r || !req;
            core_clr_r <= (state_nxt_s == ST_CLEAR);
            busy_r     <= (state_nxt_s == ST_CLEAR) || (state_nxt_s == ST_RUN);
            done_r     <= (state_nxt_s == ST_DONE);
        end
    end

    assign core_clr = core_clr_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign cycles   = cycles_r;
    assign core_en  = (state_r == ST_RUN) && !at_end_s;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed scenarios plus randomized req/prog_ctr traffic against a
// run-level reference model of run_ctrl.
module tb_run_ctrl;

    localparam int END_PC  = 128;
    localparam int LIM     = 20;
    localparam int CMAX    = 65535;
`ifdef RUN_CTRL_WDOG_EN
    localparam bit WDOG    = 1'b1;
`else
    localparam bit WDOG    = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        req      = 1'b0;
    logic [11:0] prog_ctr = 12'd0;
    logic        core_clr;
    logic        core_en;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycles;

    int n_checks = 0;
    int n_pass   = 0;

    typedef enum int {M_IDLE, M_CLEAR, M_RUN, M_DONE} mphase_t;
    mphase_t m_ph       = M_IDLE;
    int      m_cnt      = 0;
    bit      m_to       = 1'b0;
    bit      m_prev_req = 1'b0;
    bit      m_seen_low = 1'b0;

    run_ctrl #(
        .D(32'd12), .END_ADDR(32'd128), .CW(32'd16), .WDOG_LIMIT(32'd20)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .prog_ctr(prog_ctr),
        .core_clr(core_clr), .core_en(core_en), .busy(busy), .done(done),
        .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Spec-level run rules applied at one rising edge.
    function automatic void model_edge(input bit r, input int p);
        case (m_ph)
            M_IDLE:  if (r && !m_prev_req && m_seen_low) begin
                         m_ph = M_CLEAR; m_cnt = 0; m_to = 1'b0;
                     end
            M_CLEAR: m_ph = M_RUN;
            M_RUN:   if (p == END_PC) m_ph = M_DONE;
                     else if (WDOG && m_cnt == LIM) begin m_ph = M_DONE; m_to = 1'b1; end
                     else m_cnt++;
            M_DONE:  if (!r) m_ph = M_IDLE;
            default: m_ph = M_IDLE;
        endcase
        m_prev_req = r;
        if (!r) m_seen_low = 1'b1;
    endfunction

    task automatic step(input bit r, input int p);
        @(negedge clk);
        req = r;
        prog_ctr = 12'(p);
        #1;
        chk_eq("core_clr", int'(core_clr), int'(m_ph == M_CLEAR));
        chk_eq("busy", int'(busy), int'(m_ph == M_CLEAR || m_ph == M_RUN));
        chk_eq("done", int'(done), int'(m_ph == M_DONE));
        chk_eq("core_en", int'(core_en), int'(m_ph == M_RUN && p != END_PC));
        chk_eq("cycles", int'(cycles), (m_cnt > CMAX) ? CMAX : m_cnt);
        chk_eq("timeout", int'(timeout), int'(m_to));
        @(posedge clk);
        model_edge(r, p);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        #1;
        m_ph = M_IDLE; m_cnt = 0; m_to = 1'b0; m_prev_req = 1'b0; m_seen_low = 1'b0;
        chk_eq("rst_core_clr", int'(core_clr), 0);
        chk_eq("rst_core_en", int'(core_en), 0);
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_done", int'(done), 0);
        chk_eq("rst_cycles", int'(cycles), 0);
        chk_eq("rst_timeout", int'(timeout), 0);
        repeat (n) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        model_edge(req, int'(prog_ctr));
    endtask

    // Drive req high with a fixed PC until the model reaches DONE, bounded.
    task automatic run_to_done(input string tag, input int p, input int budget);
        int k;
        k = 0;
        while (m_ph != M_DONE && k < budget) begin
            step(1'b1, p);
            k++;
        end
        if (m_ph != M_DONE) chk_eq({tag, "_budget"}, 0, 1);
    endtask

    initial begin
        int pc_core;
        int k;
        bit r;
        int p;
        bit adv;
        bit clr;

        // Reset state, then start edge on the third cycle after release.
        apply_reset(2);
        step(1'b0, 0);
        step(1'b0, 0);
        step(1'b1, 0);
        chk_eq("lat_clear_cycle", int'(core_clr), 0);

        // Core model: PC cleared by core_clr, advanced by core_en.
        pc_core = 0;
        k = 0;
        while (m_ph != M_DONE && k < 400) begin
            clr = (m_ph == M_CLEAR);
            adv = (m_ph == M_RUN) && (pc_core != END_PC);
            step(1'b1, pc_core);
            if (clr) pc_core = 0;
            else if (adv) pc_core++;
            k++;
        end
        chk_eq("run128_done", int'(m_ph == M_DONE), 1);
        step(1'b1, pc_core);
        chk_eq("run128_cycles", int'(cycles), 128);
        chk_eq("run128_done_out", int'(done), 1);
        repeat (5) step(1'b1, pc_core);
        step(1'b0, pc_core);
        step(1'b0, pc_core);
        chk_eq("done_fall", int'(done), 0);

        // PC already at END_ADDR before start: one RUN cycle, cycles stays 0.
        step(1'b0, END_PC);
        step(1'b1, END_PC);
        run_to_done("pc_at_end", END_PC, 10);
        step(1'b1, END_PC);
        chk_eq("pc_at_end_cycles", int'(cycles), 0);
        step(1'b0, END_PC);

        // Mid-run reset at cycles=50 with req still high, then a fresh start.
        step(1'b0, 3);
        step(1'b1, 3);
        k = 0;
        while (m_cnt < 50 && k < 100) begin step(1'b1, 3); k++; end
        apply_reset(2);
        repeat (4) step(1'b1, 3);
        chk_eq("no_restart_busy", int'(busy), 0);
        step(1'b0, 3);
        step(1'b1, 3);
        step(1'b1, 3);
        chk_eq("restart_clear", int'(core_clr), 1);
        repeat (3) step(1'b1, 3);
        // req toggled during RUN: no restart, counting continues.
        step(1'b0, 3);
        step(1'b1, 3);
        step(1'b0, 3);
        step(1'b1, 3);
        chk_eq("toggle_no_clr", int'(core_clr), 0);

`ifdef RUN_CTRL_WDOG_EN
        run_to_done("wdog", 5, 100);
        step(1'b1, 5);
        chk_eq("wdog_timeout", int'(timeout), 1);
        chk_eq("wdog_cycles", int'(cycles), 20);
        step(1'b0, 5);
        step(1'b0, 5);
        step(1'b1, 5);
        step(1'b1, 5);
        chk_eq("wdog_clear_to", int'(timeout), 0);
`else
        repeat (60) step(1'b1, 5);
        chk_eq("nowdog_busy", int'(busy), 1);
        chk_eq("nowdog_timeout", int'(timeout), 0);
`endif
        run_to_done("finish", END_PC, 80);
        step(1'b0, 0);

        // Randomized traffic: sticky req, mostly non-end PCs, rare resets.
        r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) r = ~r;
            p = ($urandom_range(0, 15) == 0) ? END_PC : int'($urandom_range(0, 4095));
            if ($urandom_range(0, 699) == 0) apply_reset(int'($urandom_range(1, 3)));
            step(r, p);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
